fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch from the combinational instruction memory; delivers one registered instruction per cycle to the decode stage. Applies branch/jump redirects from the execute stage, stalls, halts and address-fault detection. Also arbitrates the memory write port between idle time and a program loader, so the memory is never fetched while it is being written.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after halt
MEM_BYTES, 256, instruction memory size in bytes (64 words); fetch addresses >= MEM_BYTES fault

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse: begin fetching from current PC (IDLE only)
halt_req  in  1  stop fetching, return to IDLE with PC = RESET_PC
stall  in  1  hold PC and instruction outputs
redirect_valid  in  1  taken branch / jal / jalr this cycle
redirect_pc  in  32  redirect target (byte address)
imem_addr  out  32  byte address to instruction memory (combinational from PC)
imem_rdata  in  32  combinational read data from instruction memory
instr_valid  out  1  instr/instr_pc hold a valid fetched instruction
instr  out  32  registered instruction
instr_pc  out  32  byte address instr was fetched from
load_req  in  1  loader requests memory write port
load_gnt  out  1  loader owns memory (state LOAD)
load_addr  in  32  loader byte address
load_data  in  32  loader write data
imem_we  out  1  memory write enable (= load_gnt & load_req)
imem_waddr  out  32  = load_addr while granted, else 0
imem_wdata  out  32  = load_data while granted, else 0
fault  out  1  sticky: PC out of range or misaligned redirect
busy  out  1  state is RUN

Behaviour:
- States: IDLE, LOAD, RUN, FAULT. All state changes on rising clk.
- Reset (rst_n=0 at edge): state IDLE, PC=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fault=0, load_gnt=0, busy=0. Reset mid-RUN or mid-LOAD aborts immediately; no write is issued on the reset cycle.
- imem_addr = PC at all times. Fetch latency 1 cycle: the word at PC appears on instr the edge after PC is presented.
- IDLE: instr_valid=0. load_req=1 -> LOAD (load_req wins over a simultaneous start). start=1 -> RUN. Otherwise stay.
- LOAD: load_gnt=1; imem_we follows load_req. load_req=0 -> IDLE on the next edge. start and redirect_valid are ignored. halt_req also returns to IDLE.
- RUN, per edge, priority high to low:
  1. halt_req: -> IDLE, PC=RESET_PC, instr_valid=0.
  2. redirect_valid: PC=redirect_pc; instr_valid=0 (flush wrong-path word). Applies even if stall=1. If redirect_pc[1:0]!=0 -> FAULT.
  3. stall: PC, instr, instr_pc, instr_valid unchanged.
  4. Normal: instr=imem_rdata, instr_pc=PC, instr_valid=1, PC=PC+4 (32-bit wrap).
- Range check (RUN only, before a normal fetch): if PC >= MEM_BYTES, do not capture. Go to FAULT, set instr_valid=0 and fault=1. A redirect to an out-of-range target faults on the following non-stalled cycle.
- load_req in RUN is ignored: load_gnt stays 0 and imem_we stays 0.
- FAULT: fault=1, instr_valid=0, PC frozen. Only halt_req (-> IDLE, fault cleared, PC=RESET_PC) or reset exits.
- busy=1 exactly while in RUN.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, adds output ports fetch_count[31:0] and stall_count[31:0]:
- fetch_count increments on each normal fetch (instr_valid set by a capture).
- stall_count increments on each RUN cycle with stall=1 and no redirect or halt.
- Both counters saturate at 32'hFFFF_FFFF and clear on reset or on an IDLE->RUN transition.
When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset then start, memory holding 0x00100083 at 4 and 0x00200103 at 8: instr_valid rises 1 cycle after start; instr_pc sequence 0,4,8 with matching words; PC advances by 4.
- In RUN at PC=36, assert redirect_valid with redirect_pc=44: the next cycle has instr_valid=0, the following cycle has instr_pc=44. Repeat with stall=1 in the same cycle: the redirect is still taken.
- Hold stall 3 cycles at instr_pc=12: instr, instr_pc and instr_valid are held constant for 3 cycles; fetch then resumes at instr_pc=16 (stall_count=3 with FETCH_PERF_CNT_EN).
- Let the PC run to 252 with MEM_BYTES=256: word 252 is captured, then fault=1 and instr_valid=0 at PC=256. halt_req -> IDLE, fault=0, PC=0.
- Redirect to 0x0000_0022 -> FAULT next edge with fault=1. Separately, pulse load_req in RUN -> load_gnt stays 0 and imem_we stays 0.
- In IDLE, assert load_req and start together -> LOAD. Write 0xDEADBEEF to address 60: imem_we=1, imem_waddr=60. Drop load_req -> IDLE, start -> instr at pc 60 reads 0xDEADBEEF. Reset (rst_n=0) mid-LOAD -> imem_we=0 and load_gnt=0 on the next edge.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: fetch/redirect control, instruction memory ports,
// decode-side outputs and loader handshake. Optional FETCH_PERF_CNT_EN adds counters.
interface fetch_sequencer_if;
  logic        start;
  logic        halt_req;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        load_req;
  logic        load_gnt;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        fault;
  logic        busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  modport master (
`ifdef FETCH_PERF_CNT_EN
    output fetch_count,
    output stall_count,
`endif
    input  start, halt_req, stall, redirect_valid, redirect_pc,
    input  imem_rdata, load_req, load_addr, load_data,
    output imem_addr, instr_valid, instr, instr_pc, load_gnt,
    output imem_we, imem_waddr, imem_wdata, fault, busy
  );

  modport slave (
`ifdef FETCH_PERF_CNT_EN
    input  fetch_count,
    input  stall_count,
`endif
    output start, halt_req, stall, redirect_valid, redirect_pc,
    output imem_rdata, load_req, load_addr, load_data,
    input  imem_addr, instr_valid, instr, instr_pc, load_gnt,
    input  imem_we, imem_waddr, imem_wdata, fault, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and one-word-per-cycle fetch from a combinational instruction
// memory, with redirect/stall/halt, range faults and a loader write port.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        pc_in_range_s;
  logic        load_gnt_s;

  assign pc_in_range_s = ({1'b0, pc_q} < MemLimit);
  assign load_gnt_s    = (state_q == S_LOAD);

  // Loader write port is gated by rst_n so a reset cycle never writes memory.
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fault       = fault_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.load_gnt    = load_gnt_s;
  assign bus.imem_we     = load_gnt_s & bus.load_req & rst_n;
  assign bus.imem_waddr  = load_gnt_s ? bus.load_addr : 32'h0000_0000;
  assign bus.imem_wdata  = load_gnt_s ? bus.load_data : 32'h0000_0000;

  // Next-state and datapath decision for state, PC and the decode-stage registers.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    case (state_q)
      S_IDLE: begin
        instr_valid_d = 1'b0;
        if (bus.load_req) begin
          state_d = S_LOAD;
        end else if (bus.start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        instr_valid_d = 1'b0;
        if (bus.halt_req || !bus.load_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          state_d       = S_IDLE;
          pc_d          = RESET_PC;
          instr_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          // Redirect beats stall; the in-flight word is wrong-path and dropped.
          pc_d          = bus.redirect_pc;
          instr_valid_d = 1'b0;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (bus.stall) begin
          state_d = S_RUN;
        end else if (!pc_in_range_s) begin
          state_d       = S_FAULT;
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          instr_d       = bus.imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
        end
      end
      S_FAULT: begin
        instr_valid_d = 1'b0;
        if (bus.halt_req) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
        end else begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
      end
      default: begin
        state_d       = S_IDLE;
        pc_d          = RESET_PC;
        instr_valid_d = 1'b0;
        fault_d       = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        count_fetch_s, count_stall_s, count_clear_s;

  assign count_fetch_s = (state_q == S_RUN) && !bus.halt_req && !bus.redirect_valid
                         && !bus.stall && pc_in_range_s;
  assign count_stall_s = (state_q == S_RUN) && !bus.halt_req && !bus.redirect_valid
                         && bus.stall;
  assign count_clear_s = (state_q == S_IDLE) && !bus.load_req && bus.start;
  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;

  // Saturating counters, cleared whenever a new run begins.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (count_clear_s) begin
      fetch_count_d = 32'h0000_0000;
      stall_count_d = 32'h0000_0000;
    end else begin
      if (count_fetch_s && (fetch_count_q != 32'hFFFF_FFFF)) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        fetch_count_d = fetch_count_q;
      end
      if (count_stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_d = stall_count_q + 32'd1;
      end else begin
        stall_count_d = stall_count_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 64-word memory model.
module tb_fetch_sequencer;
  logic clk;
  logic rst_n;
  logic mem_init;
  logic [31:0] mem [0:63];
  int errors;
  int checks;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .MEM_BYTES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem[1] <= 32'h0010_0083;
      mem[2] <= 32'h0020_0103;
    end else if (bus.imem_we) begin
      mem[bus.imem_waddr[7:2]] <= bus.imem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    bus.start = 1'b0;
    bus.halt_req = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.load_req = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;
    step();
    step();
    mem_init = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_fault", 32'(bus.fault), 32'h0);
    check("rst_gnt", 32'(bus.load_gnt), 32'h0);
    check("rst_pc", bus.imem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // start and sequential fetch
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_valid0", 32'(bus.instr_valid), 32'h0);
    check("start_busy", 32'(bus.busy), 32'h1);
    step();
    check("f0_valid", 32'(bus.instr_valid), 32'h1);
    check("f0_pc", bus.instr_pc, 32'h0);
    check("f0_instr", bus.instr, 32'hC0DE_0000);
    check("f0_addr", bus.imem_addr, 32'h4);
    step();
    check("f4_pc", bus.instr_pc, 32'h4);
    check("f4_instr", bus.instr, 32'h0010_0083);
    step();
    check("f8_pc", bus.instr_pc, 32'h8);
    check("f8_instr", bus.instr, 32'h0020_0103);
    check("f8_addr", bus.imem_addr, 32'hC);
    step();
    check("f12_pc", bus.instr_pc, 32'hC);

    // three stall cycles
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.instr_pc, 32'hC);
      check("stall_instr", bus.instr, 32'hC0DE_0003);
      check("stall_valid", 32'(bus.instr_valid), 32'h1);
      check("stall_addr", bus.imem_addr, 32'h10);
    end
    bus.stall = 1'b0;
    step();
    check("resume_pc", bus.instr_pc, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    check("stall_count", bus.stall_count, 32'd3);
    check("fetch_count", bus.fetch_count, 32'd5);
`endif
    for (int i = 0; i < 4; i++) step();
    check("f32_pc", bus.instr_pc, 32'h20);
    check("pc36", bus.imem_addr, 32'h24);

    // redirect, then redirect under stall
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd44;
    step();
    bus.redirect_valid = 1'b0;
    check("redir_flush", 32'(bus.instr_valid), 32'h0);
    check("redir_addr", bus.imem_addr, 32'd44);
    step();
    check("redir_pc", bus.instr_pc, 32'd44);
    check("redir_instr", bus.instr, 32'hC0DE_000B);
    check("redir_valid", 32'(bus.instr_valid), 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd100;
    bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    check("rs_flush", 32'(bus.instr_valid), 32'h0);
    check("rs_addr", bus.imem_addr, 32'd100);
    step();
    check("rs_pc", bus.instr_pc, 32'd100);
    check("rs_instr", bus.instr, 32'hC0DE_0019);

    // run off the end of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd240;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("end_pc", bus.instr_pc, 32'd252);
    check("end_instr", bus.instr, 32'hC0DE_003F);
    check("end_fault0", 32'(bus.fault), 32'h0);
    check("end_addr", bus.imem_addr, 32'd256);
    step();
    check("oor_fault", 32'(bus.fault), 32'h1);
    check("oor_valid", 32'(bus.instr_valid), 32'h0);
    check("oor_busy", 32'(bus.busy), 32'h0);
    step();
    check("oor_hold_fault", 32'(bus.fault), 32'h1);
    check("oor_hold_addr", bus.imem_addr, 32'd256);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    check("halt_fault", 32'(bus.fault), 32'h0);
    check("halt_busy", 32'(bus.busy), 32'h0);
    check("halt_pc", bus.imem_addr, 32'h0);

    // misaligned redirect
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0022;
    step();
    bus.redirect_valid = 1'b0;
    check("mis_fault", 32'(bus.fault), 32'h1);
    check("mis_addr", bus.imem_addr, 32'h22);
    check("mis_valid", 32'(bus.instr_valid), 32'h0);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    check("mis_clear", 32'(bus.fault), 32'h0);

    // load_req ignored in RUN; out-of-range redirect faults after stall
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.load_req = 1'b1;
    bus.load_addr = 32'h0;
    bus.load_data = 32'hFFFF_FFFF;
    #1;
    check("run_we_comb", 32'(bus.imem_we), 32'h0);
    step();
    check("run_gnt", 32'(bus.load_gnt), 32'h0);
    check("run_we", 32'(bus.imem_we), 32'h0);
    check("run_busy", 32'(bus.busy), 32'h1);
    bus.load_req = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_012C;
    bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("oor_stall_fault", 32'(bus.fault), 32'h0);
    bus.stall = 1'b0;
    step();
    check("oor_redir_fault", 32'(bus.fault), 32'h1);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;

    // loader: load_req wins over start
    bus.load_req = 1'b1;
    bus.start = 1'b1;
    bus.load_addr = 32'd60;
    bus.load_data = 32'hDEAD_BEEF;
    step();
    bus.start = 1'b0;
    check("load_gnt", 32'(bus.load_gnt), 32'h1);
    check("load_busy", 32'(bus.busy), 32'h0);
    check("load_we", 32'(bus.imem_we), 32'h1);
    check("load_waddr", bus.imem_waddr, 32'd60);
    check("load_wdata", bus.imem_wdata, 32'hDEAD_BEEF);
    step();
    bus.load_req = 1'b0;
    step();
    check("unload_gnt", 32'(bus.load_gnt), 32'h0);
    check("unload_we", 32'(bus.imem_we), 32'h0);
    check("unload_waddr", bus.imem_waddr, 32'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd60;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("loaded_pc", bus.instr_pc, 32'd60);
    check("loaded_instr", bus.instr, 32'hDEAD_BEEF);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;

    // reset mid-LOAD issues no write
    bus.load_req = 1'b1;
    bus.load_addr = 32'd4;
    bus.load_data = 32'h1111_1111;
    step();
    check("ml_gnt", 32'(bus.load_gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    check("ml_we_rst", 32'(bus.imem_we), 32'h0);
    step();
    check("ml_gnt_after", 32'(bus.load_gnt), 32'h0);
    check("ml_we_after", 32'(bus.imem_we), 32'h0);
    rst_n = 1'b1;
    bus.load_req = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("ml_pc4", bus.instr_pc, 32'h4);
    check("ml_word4", bus.instr, 32'h0010_0083);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
